// File: rtl/lsu_arb_pkg.sv
// lsu_arb_pkg: shared state, memory-op and region encodings for the LSU port arbiter.
package lsu_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam logic [1:0] MEM_OP_BYTE = 2'b00;
  localparam logic [1:0] MEM_OP_HALF = 2'b01;
  localparam logic [1:0] MEM_OP_WORD = 2'b10;
  localparam int MEM_OP_UNSIGNED = 2;
  localparam logic [2:0] REGION_OUT = 3'b100;
  localparam logic [2:0] REGION_IN = 3'b101;
  function automatic logic region_mapped(input logic [2:0] r);
    return !r[2] || r == REGION_OUT || r == REGION_IN;
  endfunction
endpackage

// File: rtl/lsu_access_check.sv
// lsu_access_check: flags misaligned, unmapped, illegal-size or read-only-store accesses.
module lsu_access_check
  import lsu_arb_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic        we_i,
  input  logic [10:0] addr_i,
  output logic        err_o
);
  logic [2:0] w_region;
  logic       w_misaligned;
  logic       w_bad_op;
  assign w_region = addr_i[10:8];
  assign w_misaligned = (op_i == MEM_OP_HALF && addr_i[0]) || (op_i == MEM_OP_WORD && addr_i[1:0] != 2'b00);
  assign w_bad_op = !(op_i == MEM_OP_BYTE || op_i == MEM_OP_HALF || op_i == MEM_OP_WORD);
  assign err_o = w_misaligned || w_bad_op || !region_mapped(w_region) || (we_i && w_region == REGION_IN);
endmodule

// File: rtl/lsu_port_arbiter.sv
// lsu_port_arbiter: two-requester front end for the single LSU port, fixed priority with
// starvation relief for port 1, one access per two cycles.
module lsu_port_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CW = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic        we0_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] wdata0_i,
  input  logic [2:0]  op0_i,
  input  logic        req1_i,
  input  logic        we1_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata1_i,
  input  logic [2:0]  op1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        rvalid0_o,
  output logic        rvalid1_o,
  output logic [31:0] rdata0_o,
  output logic [31:0] rdata1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic [31:0] lsu_addr_o,
  output logic        lsu_st_en_o,
  output logic [31:0] lsu_st_data_o,
  output logic [2:0]  lsu_mem_op_o,
  input  logic [31:0] lsu_ld_data_i
);
  state_e        r_state;
  logic          r_owner;
  logic          r_we;
  logic          r_err;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [2:0]    r_op;
  logic [CW-1:0] r_starve;
  logic          w_win1;
  logic          w_grant;
  logic          w_access;
  logic          w_starved;
  logic          w_we;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [2:0]    w_op;
  logic          w_err;
  assign w_starved = r_starve == CW'(STARVE_LIMIT);
  assign w_win1 = req1_i && (w_starved || !req0_i);
  assign w_grant = r_state != ACCESS && (req0_i || req1_i);
  assign w_access = r_state == ACCESS;
  assign w_we = w_win1 ? we1_i : we0_i;
  assign w_addr = w_win1 ? addr1_i : addr0_i;
  assign w_wdata = w_win1 ? wdata1_i : wdata0_i;
  assign w_op = w_win1 ? op1_i : op0_i;
  lsu_access_check u_check (
    .op_i   (w_op[1:0]),
    .we_i   (w_we),
    .addr_i (w_addr[10:0]),
    .err_o  (w_err)
  );
  assign gnt0_o = w_grant && !w_win1;
  assign gnt1_o = w_grant && w_win1;
  assign rvalid0_o = r_state == RESP && !r_owner;
  assign rvalid1_o = r_state == RESP && r_owner;
  assign err0_o = rvalid0_o && r_err;
  assign err1_o = rvalid1_o && r_err;
  assign rdata0_o = rvalid0_o ? r_rdata : '0;
  assign rdata1_o = rvalid1_o ? r_rdata : '0;
  // The LSU sees the latched request only during ACCESS; the reset drops st_en asynchronously.
  assign lsu_addr_o = w_access ? r_addr : '0;
  assign lsu_st_en_o = w_access && r_we;
  assign lsu_st_data_o = w_access ? r_wdata : '0;
  assign lsu_mem_op_o = w_access ? r_op : {1'b0, MEM_OP_WORD};
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_we <= 1'b0;
      r_err <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_op <= '0;
      r_starve <= '0;
    end else begin
      r_rdata <= (w_access && !r_we) ? lsu_ld_data_i : '0;
      if (w_grant) begin
        r_owner <= w_win1;
        r_we <= w_we;
        r_err <= w_err;
        r_addr <= w_addr;
        r_wdata <= w_wdata;
        r_op <= w_op;
        r_state <= w_err ? RESP : ACCESS;
        r_starve <= w_win1 ? '0 : (req1_i && !w_starved) ? r_starve + 1'b1 : r_starve;
      end else begin
        r_state <= w_access ? RESP : IDLE;
      end
    end
  end
endmodule

// File: tb/tb_lsu_port_arbiter.sv
// tb_lsu_port_arbiter: directed and randomized checks of the arbiter against a byte-level memory model.
module tb_lsu_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [2:0]  op0, op1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] lsu_addr, lsu_st_data, lsu_ld_data;
  logic        lsu_st_en;
  logic [2:0]  lsu_mem_op;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [0:511];
  logic [7:0]  ref_mem [0:2047];
  logic [31:0] io_sw;
  logic [31:0] lw, ls;
  int cyc = 0;
  int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_port_arbiter #(.STARVE_LIMIT(4), .CW(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0), .op0_i(op0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1), .op1_i(op1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rdata0_o(rdata0), .rdata1_o(rdata1), .err0_o(err0), .err1_o(err1),
    .lsu_addr_o(lsu_addr), .lsu_st_en_o(lsu_st_en), .lsu_st_data_o(lsu_st_data),
    .lsu_mem_op_o(lsu_mem_op), .lsu_ld_data_i(lsu_ld_data)
  );

  // LSU stand-in: word array, switch region reads io_sw, loads extended by mem_op.
  always_comb begin
    lw = (lsu_addr[10:8] == 3'b101) ? io_sw : mem[lsu_addr[10:2]];
    ls = lw >> (8 * lsu_addr[1:0]);
    lsu_ld_data = lw;
    if (lsu_mem_op[1:0] == 2'b00) lsu_ld_data = lsu_mem_op[2] ? {24'h0, ls[7:0]} : {{24{ls[7]}}, ls[7:0]};
    else if (lsu_mem_op[1:0] == 2'b01) lsu_ld_data = lsu_mem_op[2] ? {16'h0, ls[15:0]} : {{16{ls[15]}}, ls[15:0]};
  end

  always @(posedge clk) begin
    if (lsu_st_en)
      for (int i = 0; i < (lsu_mem_op[1:0] == 2'b00 ? 1 : lsu_mem_op[1:0] == 2'b01 ? 2 : 4); i++)
        mem[lsu_addr[10:2]][8*(int'(lsu_addr[1:0]) + i) +: 8] <= lsu_st_data[8*i +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_size(input logic [2:0] op);
    return op[1:0] == 2'b00 ? 1 : op[1:0] == 2'b01 ? 2 : op[1:0] == 2'b10 ? 4 : 0;
  endfunction

  function automatic bit m_err(input bit we, input logic [2:0] op, input logic [31:0] a);
    int sz;
    int r;
    sz = m_size(op);
    r = int'((a >> 8) & 32'd7);
    if (sz == 0) return 1'b1;
    return (a % sz) != 0 || r >= 6 || (we && r == 5);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] op);
    int sz;
    logic [31:0] v;
    logic [7:0] b;
    sz = m_size(op);
    v = 32'h0;
    for (int i = 0; i < sz; i++) begin
      b = (((a >> 8) & 32'd7) == 32'd5) ? 8'(io_sw >> (8 * ((a + i) % 4))) : ref_mem[(a + i) % 2048];
      v = v | (32'(b) << (8 * i));
    end
    if (!op[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [2:0] op, input logic [31:0] wd);
    for (int i = 0; i < m_size(op); i++) ref_mem[(a + i) % 2048] = wd[8*i +: 8];
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"}, {30'h0, gnt1, gnt0}, 32'h0);
    chk({tag, "_rvalid"}, {30'h0, rvalid1, rvalid0}, 32'h0);
    chk({tag, "_err"}, {30'h0, err1, err0}, 32'h0);
    chk({tag, "_rdata"}, rdata0 | rdata1, 32'h0);
    chk({tag, "_lsu_addr"}, lsu_addr, 32'h0);
    chk({tag, "_lsu_st"}, {31'h0, lsu_st_en} | lsu_st_data, 32'h0);
    chk({tag, "_lsu_op"}, 32'(lsu_mem_op), 32'h2);
  endtask

  // One request on port p, called at a negedge; returns at the negedge of its response cycle.
  task automatic xact(input int p, input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] op);
    bit e;
    bit got;
    logic [31:0] exp_rd;
    e = m_err(we, op, a);
    exp_rd = (!e && !we) ? m_load(a, op) : 32'h0;
    if (p == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; op0 = op; end
    else begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; op1 = op; end
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      #1;
      got = (p == 0) ? gnt0 : gnt1;
      if (!got) @(negedge clk);
    end
    chk("gnt", 32'(got), 32'h1);
    @(posedge clk);
    #1;
    req0 = 0;
    req1 = 0;
    if (!got) return;
    if (!e && we) m_store(a, op, wd);
    @(negedge clk);
    if (!e) begin
      chk("access_st_en", 32'(lsu_st_en), 32'(we));
      chk("access_addr", lsu_addr, a);
      chk("access_early_rvalid", {30'h0, rvalid1, rvalid0}, 32'h0);
      @(negedge clk);
    end else begin
      chk("err_st_en", 32'(lsu_st_en), 32'h0);
    end
    chk("rvalid", 32'(p == 0 ? rvalid0 : rvalid1), 32'h1);
    chk("rvalid_other", 32'(p == 0 ? rvalid1 : rvalid0), 32'h0);
    chk("err", 32'(p == 0 ? err0 : err1), 32'(e));
    chk("rdata", p == 0 ? rdata0 : rdata1, exp_rd);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] a;
    int n, ng, nrv, last;
    bit we;
    logic [2:0] op;
    rst = 1;
    {req0, we0, req1, we1} = '0;
    {addr0, wdata0, addr1, wdata1} = '0;
    op0 = 3'b010;
    op1 = 3'b010;
    io_sw = 32'hCAFE_F00D;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    rst = 0;
    @(negedge clk);

    // Both ports held: port 1 forced in every fifth grant.
    req0 = 1; addr0 = 32'h010; req1 = 1; addr1 = 32'h020;
    n = 0;
    for (int k = 0; k < 40 && n < 10; k++) begin
      #1;
      if (gnt0 || gnt1) begin
        chk("one_gnt", 32'(gnt0 & gnt1), 32'h0);
        chk("grant_seq", 32'(gnt1), 32'(exp_seq[n]));
        n++;
      end
      @(negedge clk);
    end
    chk("seq_count", 32'(n), 32'd10);
    req0 = 0;
    req1 = 0;
    repeat (2) @(negedge clk);

    xact(0, 1, 32'h004, 32'hDEAD_BEEF, 3'b010);
    xact(0, 0, 32'h004, 32'h0, 3'b010);
    chk("load_deadbeef", rdata0, 32'hDEAD_BEEF);
    xact(1, 0, 32'h101, 32'h0, 3'b001);
    io_sw = 32'h1234_5678;
    xact(0, 1, 32'h500, 32'h55, 3'b000);
    xact(0, 0, 32'h500, 32'h0, 3'b010);
    chk("load_sw", rdata0, 32'h1234_5678);

    for (int i = 0; i < 40; i++) begin
      case ($urandom % 4)
        0: a = 32'h000 + ($urandom % 64);
        1: a = 32'h400 + ($urandom % 8);
        2: a = 32'h500 + ($urandom % 8);
        default: a = ($urandom % 2) ? 32'h600 + ($urandom % 8) : 32'h0F0 + ($urandom % 16);
      endcase
      op = 3'($urandom % 8);
      if (op[1:0] == 2'b11 && ($urandom % 4) != 0) op[1:0] = 2'b10;
      we = 1'($urandom % 2);
      xact(int'($urandom % 2), we, a, $urandom, op);
    end

    // Reset during a store ACCESS must leave HEX0 untouched.
    xact(0, 1, 32'h400, 32'h1122_3344, 3'b010);
    req0 = 1; we0 = 1; addr0 = 32'h400; wdata0 = 32'hA5A5_A5A5; op0 = 3'b010;
    #1;
    chk("rst_gnt", 32'(gnt0), 32'h1);
    @(posedge clk);
    #1;
    req0 = 0;
    @(negedge clk);
    chk("rst_st_en_before", 32'(lsu_st_en), 32'h1);
    #1;
    rst = 1;
    #1;
    chk("rst_st_en_async", 32'(lsu_st_en), 32'h0);
    @(negedge clk);
    rst = 0;
    chk("hex0_kept", mem[9'h100], m_load(32'h400, 3'b010));
    for (int k = 0; k < 3; k++) begin
      chk_quiet("post_rst");
      @(negedge clk);
    end

    // Back-to-back loads: grant in each RESP cycle.
    for (int i = 0; i < 5; i++) xact(0, 1, 32'h040 + 4 * i, $urandom, 3'b010);
    req0 = 1; we0 = 0; addr0 = 32'h040; op0 = 3'b010;
    ng = 0; nrv = 0; last = 0;
    for (int k = 0; k < 40 && (ng < 5 || nrv < 5); k++) begin
      #1;
      if (rvalid0) begin
        chk("b2b_rdata", rdata0, q.size() > 0 ? q.pop_front() : 32'hXXXX_XXXX);
        nrv++;
      end
      if (gnt0) begin
        q.push_back(m_load(addr0, 3'b010));
        if (ng > 0) chk("b2b_spacing", 32'(cyc - last), 32'd2);
        last = cyc;
        ng++;
        @(posedge clk);
        #1;
        if (ng < 5) addr0 = 32'h040 + 4 * ng;
        else req0 = 0;
      end
      @(negedge clk);
    end
    chk("b2b_count", 32'(nrv), 32'd5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
